// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray-code receiver: FSM states, step classes
// and a fixed-width gray-to-binary reference function.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Zero-extended narrower codes decode correctly: leading zeros leave the prefix XOR unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        logic                  acc;
        acc = 1'b0;
        b   = '0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decoder: each binary bit is the XOR of all gray
// bits at and above its position.
module gray_to_bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    logic acc;

    always_comb begin
        acc = 1'b0;
        bin = '0;
        for (int i = N - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_decode_tracker.sv
// Two-stage gray decoder that classifies each accepted sample as hold/up/down/illegal
// against the previous position, with a sticky fault state and saturating error count.
module gray_decode_tracker
    import gray_pkg::*;
#(
    parameter int N     = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     gray_in,
    input  logic             gray_vld,
    input  logic             clr_err,
    output logic [N-1:0]     bin_out,
    output logic             bin_vld,
    output logic             dir_up,
    output logic             dir_dn,
    output logic             step_err,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt,
    output state_e           state_dbg
);

    // No backpressure: a sample is accepted whenever gray_vld is high, and
    // bin_vld pulses exactly two cycles later.
    logic [N-1:0]     s1_gray_q, s1_gray_d;
    logic             s1_vld_q, s1_vld_d;
    state_e           state_q, state_d;
    logic [N-1:0]     prev_q, prev_d;
    logic [N-1:0]     bin_out_q, bin_out_d;
    logic             bin_vld_q, bin_vld_d;
    logic             dir_up_q, dir_up_d;
    logic             dir_dn_q, dir_dn_d;
    logic             step_err_q, step_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [N-1:0]     dec;
    logic [N-1:0]     delta;
    step_e            step;

    gray_to_bin #(.N(N)) u_dec (
        .gray (s1_gray_q),
        .bin  (dec)
    );

    always_comb begin
        s1_gray_d  = gray_in;
        s1_vld_d   = gray_vld;
        state_d    = state_q;
        prev_d     = prev_q;
        bin_out_d  = bin_out_q;
        bin_vld_d  = 1'b0;
        dir_up_d   = 1'b0;
        dir_dn_d   = 1'b0;
        step_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        delta = dec - prev_q;
        if (delta == '0)             step = STEP_HOLD;
        else if (delta == N'(1))     step = STEP_UP;
        else if (delta == '1)        step = STEP_DN;
        else                         step = STEP_ERR;

        // prev follows every valid sample, illegal ones included, so checking resynchronises.
        if (s1_vld_q) begin
            bin_out_d = dec;
            bin_vld_d = 1'b1;
            prev_d    = dec;
        end

        if (clr_err) begin
            // A concurrent sample becomes the new reference, so tracking resumes right after it.
            err_cnt_d = '0;
            state_d   = s1_vld_q ? TRACK : SYNC;
        end else if (s1_vld_q) begin
            case (state_q)
                SYNC: state_d = TRACK;
                default: begin
                    dir_up_d   = (step == STEP_UP);
                    dir_dn_d   = (step == STEP_DN);
                    step_err_d = (step == STEP_ERR);
                    if (step == STEP_ERR) begin
                        state_d = FAULT;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_gray_q  <= '0;
            s1_vld_q   <= 1'b0;
            state_q    <= SYNC;
            prev_q     <= '0;
            bin_out_q  <= '0;
            bin_vld_q  <= 1'b0;
            dir_up_q   <= 1'b0;
            dir_dn_q   <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_gray_q  <= s1_gray_d;
            s1_vld_q   <= s1_vld_d;
            state_q    <= state_d;
            prev_q     <= prev_d;
            bin_out_q  <= bin_out_d;
            bin_vld_q  <= bin_vld_d;
            dir_up_q   <= dir_up_d;
            dir_dn_q   <= dir_dn_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_vld   = bin_vld_q;
    assign dir_up    = dir_up_q;
    assign dir_dn    = dir_dn_q;
    assign step_err  = step_err_q;
    assign err_cnt   = err_cnt_q;
    assign fault     = (state_q == FAULT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Directed bench for gray_decode_tracker: a cycle table checks decode, classification,
// fault and error saturation; hand sequences cover async reset mid-stream.
module tb_gray_decode_tracker;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gray_in;
    logic       gray_vld;
    logic       clr_err;

    logic [7:0] bin_out, bin_out2;
    logic       bin_vld, bin_vld2;
    logic       dir_up, dir_up2;
    logic       dir_dn, dir_dn2;
    logic       step_err, step_err2;
    logic       fault, fault2;
    logic [3:0] err_cnt;
    logic [1:0] err_cnt2;
    state_e     st1, st2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gray_decode_tracker #(.N(8), .ERR_W(4)) dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_vld(gray_vld), .clr_err(clr_err),
        .bin_out(bin_out), .bin_vld(bin_vld), .dir_up(dir_up), .dir_dn(dir_dn),
        .step_err(step_err), .fault(fault), .err_cnt(err_cnt), .state_dbg(st1)
    );

    gray_decode_tracker #(.N(8), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_vld(gray_vld), .clr_err(clr_err),
        .bin_out(bin_out2), .bin_vld(bin_vld2), .dir_up(dir_up2), .dir_dn(dir_dn2),
        .step_err(step_err2), .fault(fault2), .err_cnt(err_cnt2), .state_dbg(st2)
    );

    // One row per cycle: inputs driven this cycle, outputs expected in this same cycle
    // (i.e. the result of the inputs two rows earlier).
    typedef struct {
        logic       vld;
        logic [7:0] gray;
        logic       clr;
        logic       e_vld;
        logic [7:0] e_bin;
        logic       e_up;
        logic       e_dn;
        logic       e_err;
        logic [3:0] e_cnt;
        logic [1:0] e_cnt2;
        logic       e_fault;
        logic       f_care;
    } vec_t;

    localparam int NV = 37;
    vec_t tv[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_out();
        return 32'({bin_vld, bin_out, dir_up, dir_dn, step_err, err_cnt, err_cnt2});
    endfunction

    function automatic logic [31:0] pack_exp(input logic v, input logic [7:0] b, input logic u,
                                             input logic d, input logic e, input logic [3:0] c,
                                             input logic [1:0] c2);
        return 32'({v, b, u, d, e, c, c2});
    endfunction

    function automatic logic [31:0] pack_dut2();
        return 32'({bin_vld2, bin_out2, dir_up2, dir_dn2, step_err2, fault2});
    endfunction

    initial begin
        //          vld gray  clr  e_vld e_bin  up dn er cnt  cnt2 flt care
        // Up-count from reset
        tv[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        // Wrap up and down around 255/0
        tv[7]  = '{1'b1, 8'h80, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[9]  = '{1'b1, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[10] = '{1'b1, 8'h81, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        // Illegal skip 0 -> 2, then legal +1 while faulted
        tv[14] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[15] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[16] = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0, 1'b0};
        tv[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 4'd1, 2'd1, 1'b1, 1'b1};
        tv[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 4'd1, 2'd1, 1'b1, 1'b1};
        // Five more illegal jumps: 0x10,0x20,0x30,0x40,0x50, then clear with sample 0x60
        tv[20] = '{1'b1, 8'h18, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 4'd1, 2'd1, 1'b1, 1'b1};
        tv[21] = '{1'b1, 8'h30, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 4'd1, 2'd1, 1'b1, 1'b1};
        tv[22] = '{1'b1, 8'h28, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 4'd2, 2'd2, 1'b1, 1'b1};
        tv[23] = '{1'b1, 8'h60, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 4'd3, 2'd3, 1'b1, 1'b1};
        tv[24] = '{1'b1, 8'h78, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 4'd4, 2'd3, 1'b1, 1'b1};
        tv[25] = '{1'b1, 8'h50, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 4'd5, 2'd3, 1'b1, 1'b1};
        tv[26] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 4'd6, 2'd3, 1'b1, 1'b1};
        tv[27] = '{1'b1, 8'h51, 1'b0, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[28] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h60, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[29] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        // Gaps between samples: output held, classification against last valid value
        tv[30] = '{1'b1, 8'h53, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[31] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[32] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h62, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[33] = '{1'b1, 8'h51, 1'b0, 1'b0, 8'h62, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[34] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h62, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[35] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};
        tv[36] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1};

        // Clock/reset
        reset    = 1'b1;
        gray_in  = 8'h00;
        gray_vld = 1'b0;
        clr_err  = 1'b0;
        tick();
        tick();
        check("reset_outputs", pack_out(), pack_exp(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0));
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_state", 32'(st1), 32'(SYNC));
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            gray_in  = tv[i].gray;
            gray_vld = tv[i].vld;
            clr_err  = tv[i].clr;
            check($sformatf("row%0d_outputs", i), pack_out(),
                  pack_exp(tv[i].e_vld, tv[i].e_bin, tv[i].e_up, tv[i].e_dn,
                           tv[i].e_err, tv[i].e_cnt, tv[i].e_cnt2));
            if (tv[i].f_care) begin
                check($sformatf("row%0d_fault", i), 32'(fault), 32'(tv[i].e_fault));
            end
            // Small-counter instance must agree on everything except the counter width.
            if (tv[i].f_care) begin
                check($sformatf("row%0d_dut2", i), pack_dut2(),
                      32'({tv[i].e_vld, tv[i].e_bin, tv[i].e_up, tv[i].e_dn,
                           tv[i].e_err, tv[i].e_fault}));
            end
            tick();
        end

        // Reset while two samples are in flight
        gray_in  = 8'h53;
        gray_vld = 1'b1;
        tick();
        gray_in  = 8'h51;
        tick();
        gray_vld = 1'b0;
        gray_in  = 8'h00;
        check("pre_reset_outputs", pack_out(), pack_exp(1'b1, 8'h62, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", pack_out(), pack_exp(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0));
        check("async_reset_fault", 32'(fault), 32'd0);
        tick();
        tick();
        reset    = 1'b0;
        gray_in  = 8'hFF;
        gray_vld = 1'b1;
        tick();
        gray_vld = 1'b0;
        gray_in  = 8'h00;
        check("post_reset_inflight_dropped", pack_out(),
              pack_exp(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0));
        tick();
        check("post_reset_first_sample", pack_out(),
              pack_exp(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0));
        check("post_reset_fault", 32'(fault), 32'd0);
        tick();
        check("post_reset_idle", pack_out(),
              pack_exp(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
